// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue.
// Defines the queue entry and the fetch FSM states.
package ifq_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } ifq_state_t;

endpackage

// File: rtl/ifq_fifo.sv
// Power-of-two circular buffer of fetched instructions.
// Flush clears pointers and count in one cycle.
module ifq_fifo
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  ifq_entry_t wdata,
  input  logic       pop,
  output ifq_entry_t rdata,
  output logic       full,
  output logic       empty,
  output logic [AW:0] count
);

  ifq_entry_t mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic do_push;
  logic do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Credit-based instruction fetch with redirect flush.
// IFQ_BYPASS_EN forwards a response straight to out_* when empty.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_t    state;
  logic [31:0]   pc;
  logic [31:0]   tag_pc;
  logic          inflight;
  logic          drop;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  ifq_entry_t    head;
  ifq_entry_t    resp;
  ifq_entry_t    out_e;
  logic          resp_ok;
  logic          fifo_push;
  logic          fifo_pop;
  logic          credit;
  logic [CW:0]   occ;
  logic [CW:0]   lim;

  assign resp_ok = imem_rvalid && !drop && state != IDLE && !redirect;
  assign resp    = '{pc: tag_pc, inst: imem_rdata};
  assign fifo_pop = !empty && out_ready && !redirect;

  // Reserve a slot for every request whose response is not yet stored
  assign occ    = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign lim    = (CW+1)'(DEPTH) + {{CW{1'b0}}, fifo_pop};
  assign credit = occ < lim;

  assign imem_req  = state != IDLE && credit;
  assign imem_addr = pc;

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass    = empty && resp_ok;
  assign fifo_push = resp_ok && !(bypass && out_ready);
  assign out_valid = !empty || bypass;
  assign out_e     = !empty ? head : (bypass ? resp : '0);
`else
  assign fifo_push = resp_ok;
  assign out_valid = !empty;
  assign out_e     = empty ? '0 : head;
`endif

  assign out_pc   = out_e.pc;
  assign out_inst = out_e.inst;

  ifq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .push  (fifo_push),
    .wdata (resp),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      tag_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      inflight <= imem_req;
      drop     <= redirect && imem_req;
      if (imem_req) tag_pc <= pc;
      if (redirect) begin
        pc    <= {redirect_pc[31:2], 2'b00};
        state <= FETCH;
      end else begin
        if (imem_req) pc <= pc + 32'd4;
        unique case (state)
          IDLE:        state <= FETCH;
          FETCH, HOLD: state <= credit ? FETCH : HOLD;
          default:     state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue.
// A second instance covers PC wrap from RESET_PC=FFFFFFF8.
module tb_inst_fetch_queue;

  localparam logic [31:0] K = 32'h5A5A_5A5A;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_pc;
  logic [31:0] w_inst;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic        w_ready;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_inst    (out_inst),
    .out_ready   (out_ready)
  );

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk         (clk),
    .rst         (rst),
    .redirect    (w_redirect),
    .redirect_pc (w_redirect_pc),
    .imem_req    (w_req),
    .imem_addr   (w_addr),
    .imem_rvalid (w_rvalid),
    .imem_rdata  (w_rdata),
    .out_valid   (w_valid),
    .out_pc      (w_pc),
    .out_inst    (w_inst),
    .out_ready   (w_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_redirect    = 1'b0;
  assign w_redirect_pc = 32'h0;
  assign w_ready       = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      w_rvalid <= 1'b0;
      w_rdata  <= '0;
    end else begin
      w_rvalid <= w_req;
      w_rdata  <= w_addr ^ K;
    end
  end

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] last_pop_pc;
  logic [31:0] wexp[3];
  int n_cmp;
  int n_bad;
  int cyc;
  int n_pop;
  int n_req;
  int wcnt;
  int first_rv;
  int first_ov;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic step(input logic rdy, input logic redir,
                      input logic [31:0] rpc);
    @(negedge clk);
    imem_rvalid = pend;
    imem_rdata  = pend_addr ^ K;
    out_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    if (pend && first_rv < 0) first_rv = cyc;
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("head_pc", out_pc, exp_q[0]);
        chk("head_inst", out_inst, exp_q[0] ^ K);
        if (rdy && !redir) begin
          last_pop_pc = exp_q.pop_front();
          n_pop++;
        end
      end
    end
    if (imem_req) begin
      chk("fetch_addr", imem_addr, exp_pc);
      exp_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
      n_req++;
    end
    if (redir) begin
      exp_q.delete();
      exp_pc = {rpc[31:2], 2'b00};
    end
    pend      = imem_req;
    pend_addr = imem_addr;
    if (w_valid && wcnt < 3) begin
      chk("wrap_pc", w_pc, wexp[wcnt]);
      wcnt++;
    end
    cyc++;
  endtask

  task automatic do_reset(input logic force_rv);
    @(negedge clk);
    rst         = 1'b1;
    redirect    = 1'b0;
    out_ready   = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFF8);
    exp_q.delete();
    exp_pc = 32'h0;
    pend   = 1'b0;
    @(negedge clk);
    rst         = 1'b0;
    imem_rvalid = force_rv;
    imem_rdata  = 32'hBAD0_0000;
  endtask

  initial begin
    rst         = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    out_ready   = 1'b0;
    pend        = 1'b0;
    pend_addr   = '0;
    last_pop_pc = '0;
    exp_pc      = '0;
    wexp[0] = 32'hFFFF_FFF8;
    wexp[1] = 32'hFFFF_FFFC;
    wexp[2] = 32'h0000_0000;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    n_pop = 0;
    n_req = 0;
    wcnt  = 0;
    first_rv = -1;
    first_ov = -1;

    // streaming with a ready consumer
    do_reset(1'b0);
    repeat (10) step(1'b1, 1'b0, '0);
    n_pop = 0;
    repeat (20) step(1'b1, 1'b0, '0);
    chk("steady_pops", 32'(n_pop), 32'd20);
    chk("resp_latency", 32'(first_ov - first_rv), 32'(LAT));
    chk("wrap_seen", 32'(wcnt), 32'd3);

    // stalled consumer exhausts credit
    do_reset(1'b0);
    n_req = 0;
    repeat (10) step(1'b0, 1'b0, '0);
    chk("credit_reqs", 32'(n_req), 32'd4);
    chk("hold_req", 32'(imem_req), 32'd0);
    chk("hold_out_pc", out_pc, 32'h0);
    n_pop = 0;
    repeat (12) step(1'b1, 1'b0, '0);
    chk("drain_pops", 32'(n_pop >= 4), 32'd1);

    // redirect with a request in flight
    step(1'b1, 1'b1, 32'h0000_0103);
    step(1'b1, 1'b0, '0);
    chk("redir_valid", 32'(out_valid), 32'd0);
    chk("redir_req", 32'(imem_req), 32'd1);
    chk("redir_addr", imem_addr, 32'h0000_0100);
    n_pop = 0;
    last_pop_pc = '0;
    for (int i = 0; i < 10 && n_pop == 0; i++) step(1'b1, 1'b0, '0);
    chk("redir_first_pc", last_pop_pc, 32'h0000_0100);
    repeat (8) step(1'b1, 1'b0, '0);

    // reset with entries queued, stale response after release
    do_reset(1'b0);
    repeat (5) step(1'b0, 1'b0, '0);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_req", 32'(imem_req), 32'd0);
    do_reset(1'b1);
    n_pop = 0;
    repeat (15) step(1'b1, 1'b0, '0);
    chk("restart_pops", 32'(n_pop >= 10), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, 2..16): queue entry count.
REQ-002 SHALL have parameter RESET_PC, default 32'h0: first fetch address after reset.
REQ-003 SHALL have port clk  input  1: single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port redirect  input  1: branch/jump taken from later stage; flush and refetch.
REQ-006 SHALL have port redirect_pc  input  32: new fetch address when redirect=1.
REQ-007 SHALL have port imem_req  output  1: fetch request to instruction memory this cycle.
REQ-008 SHALL have port imem_addr  output  32: word-aligned fetch address.
REQ-009 SHALL have port imem_rvalid  input  1: response valid, exactly one cycle after accepted imem_req.
REQ-010 SHALL have port imem_rdata  input  32: instruction word for that response.
REQ-011 SHALL have port out_valid  output  1: queue head valid toward IF/ID pipeline register.
REQ-012 SHALL have port out_pc  output  32: PC of head instruction.
REQ-013 SHALL have port out_inst  output  32: head instruction word.
REQ-014 SHALL have port out_ready  input  1: IF/ID accepts head; pop when out_valid&&out_ready.

Function
REQ-015 SHALL implement FSM states IDLE (first cycle after reset), FETCH (issuing), HOLD (no credit); IDLE->FETCH unconditionally.
REQ-016 SHALL issue imem_req in FETCH only when count + inflight < DEPTH (credit check, counting same-cycle pop); otherwise HOLD until credit returns.
REQ-017 SHALL advance fetch PC by 4 per issued request, modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-018 SHALL push {pc, imem_rdata} when imem_rvalid=1 and response not marked dropped; tag each request with its PC.
REQ-019 SHALL allow push and pop in the same cycle with count unchanged; read/write pointers wrap modulo DEPTH.
REQ-020 SHALL never push when full nor pop when empty; out_valid=0 whenever count=0 (subject to REQ-028).
REQ-021 SHALL on redirect in cycle N: flush all entries, mark any in-flight response dropped, ignore same-cycle push/pop; at N+1 out_valid=0, imem_req=1, imem_addr=redirect_pc.
REQ-022 SHALL force redirect_pc[1:0] to 2'b00.
REQ-023 SHALL give redirect priority over credit exhaustion, push, and pop.
REQ-024 SHALL keep out_pc/out_inst stable while out_valid=1 and out_ready=0.

Reset
REQ-025 SHALL on rst=1 immediately clear count, pointers, inflight, drop flag; state=IDLE; fetch PC=RESET_PC.
REQ-026 SHALL hold imem_req=0, out_valid=0, imem_addr=RESET_PC, out_pc=0, out_inst=0 during reset.
REQ-027 SHALL treat reset mid-operation as full abort; a response arriving the cycle after reset deassertion SHALL be discarded.

Configuration
REQ-028 SHALL with IFQ_BYPASS_EN defined forward a response combinationally to out_* when queue empty (out_valid same cycle as imem_rvalid; stored only if out_ready=0); without it, responses always enter the queue first (out_valid earliest one cycle after imem_rvalid).

Structure
REQ-029 SHALL place shared typedef for entry {pc[31:0], inst[31:0]} and FSM state enum in package ifq_pkg.
REQ-030 SHALL implement storage as sub-module ifq_fifo (DEPTH-parameterised, push/pop/full/empty/count).

Verification
REQ-031 Reset, RESET_PC=0, out_ready=1, memory returns addr as data -> imem_addr 0,4,8,...; out_pc==out_inst each beat, one instruction per cycle steady state.
REQ-032 out_ready=0 for 10 cycles -> exactly DEPTH(4) requests issued, imem_req=0 thereafter, out_pc stays 0; release -> pops resume in order 0,4,8,12.
REQ-033 redirect=1, redirect_pc=32'h103 while one request in flight -> next cycle imem_addr=32'h100, stale response dropped, first out_pc=32'h100.
REQ-034 RESET_PC=32'hFFFFFFF8 -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
REQ-035 rst pulsed with 3 entries queued -> out_valid=0 immediately; after release fetch restarts at RESET_PC.
REQ-036 With/without IFQ_BYPASS_EN: empty queue, single response -> out_valid in same cycle vs. one cycle later.
